adder_ks_pipe: RTL and testbench
================================

ADDER_KS_PIPE -- requirements
Module: adder_ks_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/sum width; legal 4..64.
REQ-002 SHALL have parameter STAGES, default 2, register stages; legal 1..3.
REQ-003 SHALL have port i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port i_valid  input  1  operand beat valid.
REQ-006 SHALL have port o_ready  output  1  block accepts the operand beat this cycle.
REQ-007 SHALL have port i_0  input  WIDTH  operand A.
REQ-008 SHALL have port i_1  input  WIDTH  operand B.
REQ-009 SHALL have port i_c  input  1  carry-in (add) / borrow-in (sub).
REQ-010 SHALL have port i_sub  input  1  0 = A+B+c, 1 = A-B-c.
REQ-011 SHALL have port o_valid  output  1  result beat valid.
REQ-012 SHALL have port i_ready  input  1  downstream accepts the result.
REQ-013 SHALL have port o_s  output  WIDTH  sum/difference.
REQ-014 SHALL have port o_c  output  1  carry-out (sub: 1 = no borrow).
REQ-015 SHALL have port o_ovf  output  1  signed two's-complement overflow.
REQ-016 SHALL have port o_zero  output  1  o_s == 0.

Function
REQ-017 Effective operand B SHALL be i_1 XOR {WIDTH{i_sub}}; effective carry-in SHALL be i_c XOR i_sub.
REQ-018 Carry computation SHALL be a Kogge-Stone prefix tree of valency-4 black/gray cells, ceil(log4(WIDTH)) levels; no ripple chains.
REQ-019 o_s[k] SHALL be P[k] XOR G[k-1:-1]; o_c SHALL be G[WIDTH-1:-1] including carry-in.
REQ-020 o_ovf SHALL be carry into MSB XOR o_c; o_zero SHALL be NOR of o_s.
REQ-021 Register placement: STAGES=1 result register only; STAGES=2 adds register after group PG; STAGES=3 adds register after bitwise PG.
REQ-022 Latency SHALL be exactly STAGES cycles from accepted beat to o_valid with i_ready held high.
REQ-023 Beat accepted when i_valid && o_ready; result consumed when o_valid && i_ready.
REQ-024 Each stage SHALL load when empty or when its downstream stage advances (bubble-collapsing); o_ready = stage-1 empty or stage-1 advancing.
REQ-025 Throughput SHALL be one beat per cycle with i_ready high; simultaneous accept and consume on a full pipeline SHALL lose no beat.
REQ-026 With o_valid high and i_ready low, o_s/o_c/o_ovf/o_zero SHALL hold stable until consumed.
REQ-027 Beats SHALL emerge in acceptance order; no beat dropped or duplicated.
REQ-028 o_ready SHALL NOT depend combinationally on i_valid.

Reset
REQ-029 While i_rst_n=0 at a rising edge, all stage-valid bits SHALL clear; o_valid=0 next cycle.
REQ-030 Reset values: o_s=0, o_c=0, o_ovf=0, o_zero=0, o_valid=0; o_ready=1 the cycle after reset releases.
REQ-031 Reset mid-operation SHALL discard every in-flight beat; none emerges after release.

Structure
REQ-032 Shared package SHALL hold VALENCY=4, a prefix-level-count function of WIDTH, and STAGES legal-range constants.
REQ-033 One sub-module ks_prefix_level (one combinational valency-4 prefix level, parameterised by WIDTH and span) SHALL be instantiated once per level.
REQ-034 Out-of-range WIDTH or STAGES SHALL fail elaboration.

Verification
REQ-035 WIDTH=16, STAGES=2: add 0xFFFF+0x0001, c=0 -> after 2 cycles o_s=0x0000, o_c=1, o_ovf=0, o_zero=1.
REQ-036 WIDTH=16: add 0x7FFF+0x0001, c=0 -> o_s=0x8000, o_c=0, o_ovf=1, o_zero=0.
REQ-037 WIDTH=16: sub 0x8000-0x0001, c=0 -> o_s=0x7FFF, o_c=1, o_ovf=1; sub 0x0000-0x0000, c=1 -> o_s=0xFFFF, o_c=0.
REQ-038 Stream 8 beats, i_ready low 3 cycles mid-stream -> o_ready low only when full, outputs held, all 8 results in order.
REQ-039 Drop i_rst_n for 1 cycle with 2 beats in flight -> o_valid=0 next cycle, neither beat emerges, o_ready=1 after release.
REQ-040 Random add/sub, WIDTH in {4,16,33,64}, STAGES 1..3 -> all outputs match reference model, latency exactly STAGES.

Source files
------------

// File: rtl/adder_ks_pipe_pkg.sv
// Shared constants and helpers for the pipelined Kogge-Stone adder.
// VALENCY      : radix of each prefix cell (4 groups merged per cell).
// *_MIN/*_MAX  : legal parameter ranges, checked at elaboration by the top.
// ks_levels()  : number of valency-4 prefix levels needed to span a word.
package adder_ks_pipe_pkg;

  localparam int VALENCY    = 4;
  localparam int WIDTH_MIN  = 4;
  localparam int WIDTH_MAX  = 64;
  localparam int STAGES_MIN = 1;
  localparam int STAGES_MAX = 3;

  // Smallest L with VALENCY**L >= width, i.e. ceil(log4(width)).
  function automatic int ks_levels(input int width);
    int lv;
    int span;
    lv   = 0;
    span = 1;
    while (span < width) begin
      span = span * VALENCY;
      lv   = lv + 1;
    end
    return lv;
  endfunction

endpackage

// File: rtl/adder_ks_pipe_prefix_level.sv
// One combinational level of a valency-4 Kogge-Stone prefix tree.
// Each position j merges its group with the groups ending at j-SPAN,
// j-2*SPAN and j-3*SPAN (where those exist). Positions with no lower
// neighbour pass their group through unchanged (gray/buffer behaviour).
// Ports:
//   i_p, i_g : group propagate/generate entering this level
//   o_p, o_g : group propagate/generate covering 4x the input span
module ks_prefix_level
  import adder_ks_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SPAN  = 1
) (
  input  logic [WIDTH-1:0] i_p,
  input  logic [WIDTH-1:0] i_g,
  output logic [WIDTH-1:0] o_p,
  output logic [WIDTH-1:0] o_g
);

  always_comb begin
    logic gacc;
    logic pacc;
    gacc = 1'b0;
    pacc = 1'b0;
    o_p  = '0;
    o_g  = '0;
    for (int j = 0; j < WIDTH; j++) begin
      gacc = i_g[j];
      pacc = i_p[j];
      // Fold in successively lower groups: G = G_hi | P_hi & G_lo.
      for (int k = 1; k < VALENCY; k++) begin
        if (j >= k * SPAN) begin
          gacc = gacc | (pacc & i_g[j - k * SPAN]);
          pacc = pacc & i_p[j - k * SPAN];
        end
      end
      o_g[j] = gacc;
      o_p[j] = pacc;
    end
  end

endmodule

// File: rtl/adder_ks_pipe.sv
// Pipelined add/subtract unit built on a valency-4 Kogge-Stone carry tree,
// with a valid/ready handshake on both sides and bubble-collapsing stages.
// Ports:
//   i_clk, i_rst_n     : clock, synchronous active-low reset
//   i_valid / o_ready  : operand beat handshake
//   i_0, i_1           : operands A and B
//   i_c                : carry-in (add) or borrow-in (sub)
//   i_sub              : 0 = A+B+c, 1 = A-B-c
//   o_valid / i_ready  : result beat handshake
//   o_s                : sum/difference
//   o_c                : carry-out (sub: 1 = no borrow)
//   o_ovf              : signed overflow
//   o_zero             : o_s == 0
// Register placement by STAGES:
//   1 : result register only
//   2 : + register after the group PG tree
//   3 : + register after bitwise PG
module adder_ks_pipe
  import adder_ks_pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_0,
  input  logic [WIDTH-1:0] i_1,
  input  logic             i_c,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_s,
  output logic             o_c,
  output logic             o_ovf,
  output logic             o_zero
);

  localparam int LEVELS  = ks_levels(WIDTH);
  localparam int OUT_IDX = STAGES - 1;
  localparam int GRP_IDX = STAGES - 2;

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("adder_ks_pipe: WIDTH %0d outside %0d..%0d", WIDTH, WIDTH_MIN, WIDTH_MAX);
  end
  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("adder_ks_pipe: STAGES %0d outside %0d..%0d", STAGES, STAGES_MIN, STAGES_MAX);
  end

  // Handshake control. Index 0 is the first register, OUT_IDX the result.
  logic [STAGES-1:0] r_vld_p;
  logic [STAGES-1:0] w_en;
  logic [STAGES-1:0] w_vld_in;
  logic [STAGES-1:0] w_ld;

  // A stage may load when it is empty or its own content moves on; the
  // chain is evaluated from the output back so o_ready never sees i_valid.
  always_comb begin
    logic en_acc;
    en_acc        = !r_vld_p[OUT_IDX] || i_ready;
    w_en          = '0;
    w_en[OUT_IDX] = en_acc;
    for (int i = OUT_IDX - 1; i >= 0; i--) begin
      en_acc  = !r_vld_p[i] || en_acc;
      w_en[i] = en_acc;
    end
  end

  if (STAGES == 1) begin : g_vin_one
    assign w_vld_in = i_valid;
  end else begin : g_vin_many
    assign w_vld_in = {r_vld_p[STAGES-2:0], i_valid};
  end

  // Data registers only capture real beats, so idle cycles leave them intact.
  assign w_ld = w_en & w_vld_in;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_vld_p <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (w_en[i]) r_vld_p[i] <= w_vld_in[i];
      end
    end
  end

  assign o_ready = w_en[0];
  assign o_valid = r_vld_p[OUT_IDX];

  // Operand conditioning and bitwise PG: subtract is A + ~B + ~borrow.
  logic [WIDTH-1:0] w_bx;
  logic [WIDTH-1:0] w_p_a;
  logic [WIDTH-1:0] w_g_a;
  logic             w_cin_a;

  assign w_bx    = i_1 ^ {WIDTH{i_sub}};
  assign w_cin_a = i_c ^ i_sub;
  assign w_p_a   = i_0 ^ w_bx;
  assign w_g_a   = i_0 & w_bx;

  logic [WIDTH-1:0] w_p_b;
  logic [WIDTH-1:0] w_g_b;
  logic             w_cin_b;

  // ---- stage boundary: bitwise PG -> prefix tree ----
  if (STAGES == 3) begin : g_pg_reg
    logic [WIDTH-1:0] r_p_p0;
    logic [WIDTH-1:0] r_g_p0;
    logic             r_cin_p0;
    always_ff @(posedge i_clk) begin
      if (w_ld[0]) begin
        r_p_p0   <= w_p_a;
        r_g_p0   <= w_g_a;
        r_cin_p0 <= w_cin_a;
      end
    end
    assign w_p_b   = r_p_p0;
    assign w_g_b   = r_g_p0;
    assign w_cin_b = r_cin_p0;
  end else begin : g_pg_thru
    assign w_p_b   = w_p_a;
    assign w_g_b   = w_g_a;
    assign w_cin_b = w_cin_a;
  end

  // Prefix tree over bits 0..WIDTH-1; carry-in is merged after the tree
  // with one AND-OR per bit, which keeps every level purely positional.
  logic [WIDTH-1:0] w_tp [LEVELS+1];
  logic [WIDTH-1:0] w_tg [LEVELS+1];

  assign w_tp[0] = w_p_b;
  assign w_tg[0] = w_g_b;

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    ks_prefix_level #(
      .WIDTH (WIDTH),
      .SPAN  (VALENCY ** l)
    ) u_lvl (
      .i_p (w_tp[l]),
      .i_g (w_tg[l]),
      .o_p (w_tp[l+1]),
      .o_g (w_tg[l+1])
    );
  end

  logic [WIDTH-1:0] w_p_c;
  logic [WIDTH-1:0] w_gg_c;
  logic [WIDTH-1:0] w_gp_c;
  logic             w_cin_c;

  // ---- stage boundary: group PG -> sum ----
  if (STAGES >= 2) begin : g_grp_reg
    logic [WIDTH-1:0] r_p_p1;
    logic [WIDTH-1:0] r_gg_p1;
    logic [WIDTH-1:0] r_gp_p1;
    logic             r_cin_p1;
    always_ff @(posedge i_clk) begin
      if (w_ld[GRP_IDX]) begin
        r_p_p1   <= w_p_b;
        r_gg_p1  <= w_tg[LEVELS];
        r_gp_p1  <= w_tp[LEVELS];
        r_cin_p1 <= w_cin_b;
      end
    end
    assign w_p_c   = r_p_p1;
    assign w_gg_c  = r_gg_p1;
    assign w_gp_c  = r_gp_p1;
    assign w_cin_c = r_cin_p1;
  end else begin : g_grp_thru
    assign w_p_c   = w_p_b;
    assign w_gg_c  = w_tg[LEVELS];
    assign w_gp_c  = w_tp[LEVELS];
    assign w_cin_c = w_cin_b;
  end

  // w_cy[k] is the carry into bit k, i.e. G[k-1:-1]; w_cy[WIDTH] is carry-out.
  logic [WIDTH:0]   w_cy;
  logic [WIDTH-1:0] w_s;
  logic             w_co;
  logic             w_ovf;
  logic             w_zero;

  assign w_cy[0]       = w_cin_c;
  assign w_cy[WIDTH:1] = w_gg_c | (w_gp_c & {WIDTH{w_cin_c}});
  assign w_s           = w_p_c ^ w_cy[WIDTH-1:0];
  assign w_co          = w_cy[WIDTH];
  assign w_ovf         = w_cy[WIDTH-1] ^ w_cy[WIDTH];
  assign w_zero        = ~|w_s;

  logic [WIDTH-1:0] r_s_p2;
  logic             r_c_p2;
  logic             r_ovf_p2;
  logic             r_zero_p2;

  // ---- stage boundary: result register ----
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s_p2    <= '0;
      r_c_p2    <= 1'b0;
      r_ovf_p2  <= 1'b0;
      r_zero_p2 <= 1'b0;
    end else if (w_ld[OUT_IDX]) begin
      r_s_p2    <= w_s;
      r_c_p2    <= w_co;
      r_ovf_p2  <= w_ovf;
      r_zero_p2 <= w_zero;
    end
  end

  assign o_s    = r_s_p2;
  assign o_c    = r_c_p2;
  assign o_ovf  = r_ovf_p2;
  assign o_zero = r_zero_p2;

endmodule

// File: tb/tb_adder_ks_pipe.sv
module tb_adder_ks_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;

  typedef struct {
    logic [63:0] s;
    logic        c;
    logic        ovf;
    logic        zero;
    int          due;
  } exp_t;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain wide arithmetic on unsigned and signed interpretations.
  function automatic exp_t ref_model(input int w, input logic [63:0] a, input logic [63:0] b,
                                     input logic c, input logic sub);
    logic [65:0]        mask, ua, ub, uc, t;
    logic signed [65:0] sa, sb, sc, r, hi, lo;
    exp_t               e;
    mask = (66'd1 << w) - 66'd1;
    ua   = {2'b00, a} & mask;
    ub   = {2'b00, b} & mask;
    uc   = {65'd0, c};
    if (!sub) begin
      t   = ua + ub + uc;
      e.c = t[w];
    end else begin
      t   = ua - ub - uc;
      e.c = (ua >= ub + uc);
    end
    e.s = 64'(t & mask);
    sa  = ua;
    if (ua[w-1]) sa = sa - (66'sd1 <<< w);
    sb  = ub;
    if (ub[w-1]) sb = sb - (66'sd1 <<< w);
    sc  = uc;
    r   = sub ? (sa - sb - sc) : (sa + sb + sc);
    hi  = (66'sd1 <<< (w - 1)) - 66'sd1;
    lo  = -(66'sd1 <<< (w - 1));
    e.ovf  = (r > hi) || (r < lo);
    e.zero = (e.s == 64'd0);
    e.due  = 0;
    return e;
  endfunction

  // Directed instance: WIDTH=16, STAGES=2.
  logic        d_rst_n, d_vld, d_rdy_o, d_c, d_sub, d_vld_o, d_rdy_i, d_co, d_ovf, d_zero;
  logic [15:0] d_a, d_b, d_s;

  adder_ks_pipe #(.WIDTH(16), .STAGES(2)) u_dut (
    .i_clk   (clk),
    .i_rst_n (d_rst_n),
    .i_valid (d_vld),
    .o_ready (d_rdy_o),
    .i_0     (d_a),
    .i_1     (d_b),
    .i_c     (d_c),
    .i_sub   (d_sub),
    .o_valid (d_vld_o),
    .i_ready (d_rdy_i),
    .o_s     (d_s),
    .o_c     (d_co),
    .o_ovf   (d_ovf),
    .o_zero  (d_zero)
  );

  task automatic dir_vec(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic c, input logic sub, input logic [15:0] es,
                         input logic ec, input logic eovf, input logic ez);
    @(posedge clk); #1;
    d_a = a; d_b = b; d_c = c; d_sub = sub; d_vld = 1'b1; d_rdy_i = 1'b1;
    @(negedge clk);
    chk({tag, "_rdy"}, 64'(d_rdy_o), 64'd1);
    @(posedge clk); #1;
    d_vld = 1'b0;
    @(negedge clk);
    chk({tag, "_early"}, 64'(d_vld_o), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_vld"}, 64'(d_vld_o), 64'd1);
    chk({tag, "_s"}, 64'(d_s), 64'(es));
    chk({tag, "_c"}, 64'(d_co), 64'(ec));
    chk({tag, "_ovf"}, 64'(d_ovf), 64'(eovf));
    chk({tag, "_zero"}, 64'(d_zero), 64'(ez));
  endtask

  logic rnd_rst_n;
  initial begin
    rnd_rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rnd_rst_n = 1'b1;
  end

  // Randomised instances over every WIDTH/STAGES combination.
  for (genvar wi = 0; wi < 4; wi++) begin : g_w
    for (genvar si = 1; si <= 3; si++) begin : g_s
      localparam int W = (wi == 0) ? 4 : (wi == 1) ? 16 : (wi == 2) ? 33 : 64;
      logic         vi, ro, vo, ri, ci, subi, co, ov, zo;
      logic [W-1:0] a, b, s;

      adder_ks_pipe #(.WIDTH(W), .STAGES(si)) u_dut (
        .i_clk   (clk),
        .i_rst_n (rnd_rst_n),
        .i_valid (vi),
        .o_ready (ro),
        .i_0     (a),
        .i_1     (b),
        .i_c     (ci),
        .i_sub   (subi),
        .o_valid (vo),
        .i_ready (ri),
        .o_s     (s),
        .o_c     (co),
        .o_ovf   (ov),
        .o_zero  (zo)
      );

      initial begin
        exp_t        q[$];
        exp_t        e;
        int          cyc;
        logic [63:0] ra, rb;
        string       tg;
        tg = $sformatf("w%0d_s%0d", W, si);
        vi = 1'b0; ri = 1'b1; a = '0; b = '0; ci = 1'b0; subi = 1'b0; cyc = 0;
        @(posedge rnd_rst_n);
        for (int t = 0; t < 340; t++) begin
          @(posedge clk);
          cyc++;
          #1;
          if (t < 120) begin
            vi = ($urandom_range(0, 3) != 0);
            ri = 1'b1;
          end else if (t < 320) begin
            vi = 1'($urandom_range(0, 1));
            ri = ($urandom_range(0, 2) != 0);
          end else begin
            vi = 1'b0;
            ri = 1'b1;
          end
          ra = {$urandom(), $urandom()};
          rb = {$urandom(), $urandom()};
          case ($urandom_range(0, 5))
            0: ra = '1;
            1: ra = '0;
            default: ;
          endcase
          case ($urandom_range(0, 5))
            0: rb = '1;
            1: rb = 64'd1;
            default: ;
          endcase
          a    = W'(ra);
          b    = W'(rb);
          ci   = 1'($urandom_range(0, 1));
          subi = 1'($urandom_range(0, 1));
          @(negedge clk);
          if (t < 120)
            chk({tg, "_lat_vld"}, 64'(vo), 64'((q.size() > 0) && (q[0].due == cyc)));
          if (vo) begin
            if (q.size() == 0) begin
              chk({tg, "_spurious"}, 64'(vo), 64'd0);
            end else begin
              chk({tg, "_s"}, 64'(s), q[0].s);
              chk({tg, "_c"}, 64'(co), 64'(q[0].c));
              chk({tg, "_ovf"}, 64'(ov), 64'(q[0].ovf));
              chk({tg, "_zero"}, 64'(zo), 64'(q[0].zero));
              if (ri) void'(q.pop_front());
            end
          end
          if (vi && ro) begin
            e     = ref_model(W, 64'(a), 64'(b), ci, subi);
            e.due = cyc + si;
            q.push_back(e);
          end
        end
        chk({tg, "_drain"}, 64'(q.size()), 64'd0);
        n_done++;
      end
    end
  end

  logic [15:0] st_a [8];
  logic [15:0] st_b [8];
  logic        st_c [8];
  logic        st_sub [8];

  initial begin
    exp_t e;
    int   acc, con;
    d_rst_n = 1'b0; d_vld = 1'b0; d_rdy_i = 1'b1;
    d_a = '0; d_b = '0; d_c = 1'b0; d_sub = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_vld", 64'(d_vld_o), 64'd0);
    chk("rst_s", 64'(d_s), 64'd0);
    chk("rst_c", 64'(d_co), 64'd0);
    chk("rst_ovf", 64'(d_ovf), 64'd0);
    chk("rst_zero", 64'(d_zero), 64'd0);
    @(posedge clk); #1;
    d_rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rdy_rel", 64'(d_rdy_o), 64'd1);

    dir_vec("add_ffff_1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    dir_vec("add_7fff_1", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    dir_vec("sub_8000_1", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    dir_vec("sub_0_0_b1", 16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);

    // Stream of 8 beats with a 3-cycle downstream stall.
    for (int i = 0; i < 8; i++) begin
      st_a[i]   = 16'($urandom());
      st_b[i]   = 16'($urandom());
      st_c[i]   = 1'($urandom_range(0, 1));
      st_sub[i] = 1'($urandom_range(0, 1));
    end
    acc = 0;
    con = 0;
    for (int cyc = 0; cyc < 40 && con < 8; cyc++) begin
      @(posedge clk); #1;
      d_vld = (acc < 8);
      if (acc < 8) begin
        d_a = st_a[acc]; d_b = st_b[acc]; d_c = st_c[acc]; d_sub = st_sub[acc];
      end
      d_rdy_i = !(cyc >= 4 && cyc < 7);
      @(negedge clk);
      chk("strm_rdy", 64'(d_rdy_o), 64'(!((acc - con) == 2 && !d_rdy_i)));
      if (d_vld_o) begin
        if (con >= 8) begin
          chk("strm_extra", 64'(d_vld_o), 64'd0);
        end else begin
          e = ref_model(16, 64'(st_a[con]), 64'(st_b[con]), st_c[con], st_sub[con]);
          chk("strm_s", 64'(d_s), e.s);
          chk("strm_c", 64'(d_co), 64'(e.c));
          chk("strm_ovf", 64'(d_ovf), 64'(e.ovf));
          chk("strm_zero", 64'(d_zero), 64'(e.zero));
          if (d_rdy_i) con++;
        end
      end
      if (d_vld && d_rdy_o) acc++;
    end
    chk("strm_count", 64'(con), 64'd8);

    // Reset with two beats in flight and downstream stalled.
    @(posedge clk); #1;
    d_vld = 1'b1; d_rdy_i = 1'b0; d_a = 16'h1234; d_b = 16'h1111; d_c = 1'b0; d_sub = 1'b0;
    @(posedge clk); #1;
    d_a = 16'h4321; d_b = 16'h0101;
    @(posedge clk); #1;
    d_vld = 1'b0; d_rst_n = 1'b0;
    @(posedge clk); #1;
    d_rst_n = 1'b1; d_rdy_i = 1'b1;
    @(negedge clk);
    chk("rst2_vld", 64'(d_vld_o), 64'd0);
    chk("rst2_rdy", 64'(d_rdy_o), 64'd1);
    chk("rst2_s", 64'(d_s), 64'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rst2_ghost", 64'(d_vld_o), 64'd0);
    end

    for (int i = 0; i < 3000 && n_done < 12; i++) @(posedge clk);
    chk("rand_done", 64'(n_done), 64'd12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
